if_agc: RTL and testbench

Automatic gain controller for the 455 kHz IF filter stage. It watches the filter's 8-bit output, measures the peak magnitude over fixed windows, and drives the filter's 3-bit output-scaling select. Gain steps down immediately on overload (fast attack) and steps up only after a quiet window plus a settling hold (slow decay). When the SPI register disables AGC, the manual gain from the SPI register passes through to the filter.

---
 rtl/sdr_pkg.sv | 24 ++
 rtl/if_peak_detect.sv | 61 ++++++
 rtl/if_agc.sv | 133 +++++++++++++
 tb/tb_if_agc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared types and defaults for the SDR receive-chain blocks.
// Holds the AGC state encoding, gain width and default thresholds.
package sdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } agc_state_e;

  localparam int GAIN_W = 3;
  localparam int GAIN_MAX = 5;

  localparam int DEF_WINDOW_LOG2  = 10;
  localparam int DEF_HI_THRESH    = 96;
  localparam int DEF_LO_THRESH    = 24;
  localparam int DEF_HOLD_WINDOWS = 2;

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g,
                                                   input logic [GAIN_W-1:0] gmax);
    return (g > gmax) ? gmax : g;
  endfunction

endpackage

// File: rtl/if_peak_detect.sv
// Magnitude, clip detection and windowed peak tracking for the IF AGC.
// The window counter wraps on its own at window end; clear forces a fresh window.
module if_peak_detect #(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   RSTb,
  input  logic                   clear,
  input  logic                   sample_valid,
  input  logic signed [7:0]      if_filt_out,
  output logic [6:0]             mag,
  output logic                   clip_sample,
  output logic [6:0]             peak_final,
  output logic                   win_end
);

  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [6:0]             peak_q, peak_d;
  logic [7:0]             neg_x;

  // -128 has no positive 8-bit counterpart, so it saturates to 127
  always_comb begin
    neg_x = ~if_filt_out + 8'd1;
    if (if_filt_out == -8'sd128) begin
      mag = 7'd127;
    end else if (if_filt_out[7]) begin
      mag = neg_x[6:0];
    end else begin
      mag = if_filt_out[6:0];
    end
    clip_sample = (if_filt_out == 8'sd127) || (if_filt_out == -8'sd128);
  end

  always_comb begin
    peak_final = (mag > peak_q) ? mag : peak_q;
    win_end    = sample_valid && (cnt_q == '1);
  end

  always_comb begin
    cnt_d  = cnt_q;
    peak_d = peak_q;
    if (clear) begin
      cnt_d  = '0;
      peak_d = '0;
    end else if (sample_valid) begin
      cnt_d  = cnt_q + 1'b1;
      peak_d = win_end ? 7'd0 : peak_final;
    end
  end

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      cnt_q  <= '0;
      peak_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
    end
  end

endmodule

// File: rtl/if_agc.sv
// Automatic gain control for the 455 kHz IF filter: fast attack on overload,
// slow decay gated by a hold period, and a manual pass-through when disabled.
module if_agc #(
  parameter int WINDOW_LOG2  = sdr_pkg::DEF_WINDOW_LOG2,
  parameter int HI_THRESH    = sdr_pkg::DEF_HI_THRESH,
  parameter int LO_THRESH    = sdr_pkg::DEF_LO_THRESH,
  parameter int HOLD_WINDOWS = sdr_pkg::DEF_HOLD_WINDOWS,
  parameter int GAIN_MAX     = sdr_pkg::GAIN_MAX
) (
  input  logic                      clk,
  input  logic                      RSTb,
  input  logic                      sample_valid,
  input  logic signed [7:0]         if_filt_out,
  input  logic                      agc_enable,
  input  logic [sdr_pkg::GAIN_W-1:0] gain_manual,
  output logic [sdr_pkg::GAIN_W-1:0] gain_out,
  output logic                      gain_update,
  output logic                      clip,
  output logic [6:0]                peak_out
);

  import sdr_pkg::*;

  localparam int HOLD_W = (HOLD_WINDOWS < 2) ? 1 : $clog2(HOLD_WINDOWS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_WINDOWS);
  localparam logic [GAIN_W-1:0] GMAX      = GAIN_W'(GAIN_MAX);
  localparam logic [7:0]        HI_T      = 8'(HI_THRESH);
  localparam logic [7:0]        LO_T      = 8'(LO_THRESH);

  agc_state_e          state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [6:0]          peak_out_q, peak_out_d;
  logic                clip_q, clip_d;
  logic                gain_update_q, gain_update_d;

  logic                restart;
  logic                clear_win;
  logic [6:0]          mag;
  logic                clip_sample;
  logic [6:0]          peak_final;
  logic                win_end;

  assign clear_win = !agc_enable || (state_q == IDLE) || restart;

  if_peak_detect #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_peak (
    .clk         (clk),
    .RSTb        (RSTb),
    .clear       (clear_win),
    .sample_valid(sample_valid),
    .if_filt_out (if_filt_out),
    .mag         (mag),
    .clip_sample (clip_sample),
    .peak_final  (peak_final),
    .win_end     (win_end)
  );

  // A clip with gain above zero pre-empts any simultaneous window-end decision
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    hold_d     = hold_q;
    peak_out_d = peak_out_q;
    clip_d     = 1'b0;
    restart    = 1'b0;

    if (!agc_enable) begin
      state_d = IDLE;
      gain_d  = clamp_gain(gain_manual, GMAX);
      hold_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = MEASURE;
      hold_d  = '0;
    end else if (sample_valid) begin
      clip_d = clip_sample;
      if (win_end) begin
        peak_out_d = peak_final;
      end
      if (clip_sample && (gain_q != '0)) begin
        gain_d  = gain_q - 1'b1;
        hold_d  = HOLD_LOAD;
        state_d = HOLD;
        restart = 1'b1;
      end else if (win_end) begin
        if (({1'b0, peak_final} >= HI_T) && (gain_q != '0)) begin
          gain_d  = gain_q - 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = HOLD;
        end else if (({1'b0, peak_final} < LO_T) && (state_q == MEASURE) &&
                     (gain_q < GMAX)) begin
          gain_d  = gain_q + 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = HOLD;
        end else if (state_q == HOLD) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_d  = '0;
            state_d = MEASURE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
    end

    gain_update_d = (gain_d != gain_q);
  end

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      state_q       <= IDLE;
      gain_q        <= '0;
      hold_q        <= '0;
      peak_out_q    <= '0;
      clip_q        <= 1'b0;
      gain_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain_q        <= gain_d;
      hold_q        <= hold_d;
      peak_out_q    <= peak_out_d;
      clip_q        <= clip_d;
      gain_update_q <= gain_update_d;
    end
  end

  assign gain_out    = gain_q;
  assign gain_update = gain_update_q;
  assign clip        = clip_q;
  assign peak_out    = peak_out_q;

endmodule

// File: tb/tb_if_agc.sv
// Scoreboard bench for if_agc with 16-sample windows: a behavioural model
// queues the expected outputs per cycle, and directed checks pin key points.
module tb_if_agc;

  localparam int WLOG2 = 4;
  localparam int WIN   = 16;

  logic              clk = 1'b0;
  logic              RSTb = 1'b0;
  logic              sample_valid = 1'b0;
  logic signed [7:0] if_filt_out = '0;
  logic              agc_enable = 1'b0;
  logic [2:0]        gain_manual = '0;
  logic [2:0]        gain_out;
  logic              gain_update;
  logic              clip;
  logic [6:0]        peak_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int gain;
    int upd;
    int clp;
    int peak;
  } exp_t;

  exp_t sbq[$];

  int m_state = 0;
  int m_gain = 0;
  int m_cnt = 0;
  int m_peak = 0;
  int m_hold = 0;
  int m_peak_out = 0;

  if_agc #(
    .WINDOW_LOG2(WLOG2)
  ) dut (
    .clk         (clk),
    .RSTb        (RSTb),
    .sample_valid(sample_valid),
    .if_filt_out (if_filt_out),
    .agc_enable  (agc_enable),
    .gain_manual (gain_manual),
    .gain_out    (gain_out),
    .gain_update (gain_update),
    .clip        (clip),
    .peak_out    (peak_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_gain = 0;
    m_cnt = 0;
    m_peak = 0;
    m_hold = 0;
    m_peak_out = 0;
    sbq.delete();
  endtask

  // Behavioural reference: states 0 idle, 1 measure, 2 hold
  task automatic modelStep(input bit v, input int x, input bit en, input int man, output exp_t e);
    int g_old;
    int mag;
    int pk;
    bit is_clip;
    bit last;
    g_old = m_gain;
    e.clp = 0;
    if (!en) begin
      m_state = 0;
      m_gain = (man > 5) ? 5 : man;
      m_cnt = 0;
      m_peak = 0;
      m_hold = 0;
    end else if (m_state == 0) begin
      m_state = 1;
      m_cnt = 0;
      m_peak = 0;
    end else if (v) begin
      mag = (x < 0) ? -x : x;
      if (mag > 127) mag = 127;
      is_clip = (x == 127) || (x == -128);
      if (mag > m_peak) m_peak = mag;
      m_cnt++;
      last = (m_cnt == WIN);
      if (is_clip) e.clp = 1;
      if (last) m_peak_out = m_peak;
      if (is_clip && m_gain > 0) begin
        m_gain--;
        m_hold = 2;
        m_state = 2;
        m_cnt = 0;
        m_peak = 0;
      end else if (last) begin
        pk = m_peak;
        m_cnt = 0;
        m_peak = 0;
        if (pk >= 96 && m_gain > 0) begin
          m_gain--;
          m_hold = 2;
          m_state = 2;
        end else if (pk < 24 && m_state == 1 && m_gain < 5) begin
          m_gain++;
          m_hold = 2;
          m_state = 2;
        end else if (m_state == 2) begin
          m_hold--;
          if (m_hold <= 0) begin
            m_hold = 0;
            m_state = 1;
          end
        end
      end
    end
    e.gain = m_gain;
    e.upd = (m_gain != g_old) ? 1 : 0;
    e.peak = m_peak_out;
  endtask

  task automatic applyStimulus(input bit v, input int x, input bit en, input int man);
    exp_t e;
    sample_valid = v;
    if_filt_out = 8'(x);
    agc_enable = en;
    gain_manual = 3'(man);
    modelStep(v, x, en, man, e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      checkOutput("sb_gain", gain_out, e.gain);
      checkOutput("sb_update", gain_update, e.upd);
      checkOutput("sb_clip", clip, e.clp);
      checkOutput("sb_peak", peak_out, e.peak);
    end
  endtask

  task automatic enterAuto(input int man);
    applyStimulus(0, 0, 0, man);
    applyStimulus(0, 0, 1, man);
  endtask

  initial begin
    bit en_r;
    int x;
    int r;
    int man_r;

    // 1: reset and clamped manual gain
    RSTb = 1'b0;
    agc_enable = 1'b0;
    gain_manual = 3'd7;
    #12;
    checkOutput("rst_gain", gain_out, 0);
    checkOutput("rst_update", gain_update, 0);
    checkOutput("rst_clip", clip, 0);
    checkOutput("rst_peak", peak_out, 0);
    modelReset();
    @(negedge clk);
    RSTb = 1'b1;
    applyStimulus(0, 0, 0, 7);
    checkOutput("t1_gain_clamped", gain_out, 5);
    checkOutput("t1_update_pulse", gain_update, 1);
    applyStimulus(1, -128, 0, 7);
    checkOutput("t1_update_once", gain_update, 0);
    checkOutput("t1_no_clip_idle", clip, 0);

    // 2: quiet input, slow decay with hold
    enterAuto(0);
    for (int i = 1; i <= 4 * WIN; i++) begin
      applyStimulus(1, (i % 2) ? 10 : -10, 1, 0);
      if (i == WIN - 1) checkOutput("t2_gain_pre", gain_out, 0);
      if (i == WIN) begin
        checkOutput("t2_gain_first", gain_out, 1);
        checkOutput("t2_peak", peak_out, 10);
      end
      if (i == 3 * WIN) checkOutput("t2_gain_held", gain_out, 1);
      if (i == 4 * WIN) checkOutput("t2_gain_second", gain_out, 2);
    end

    // 3: loud window at gain 3
    enterAuto(3);
    for (int i = 1; i <= WIN; i++) begin
      applyStimulus(1, (i == 7) ? 100 : ((i % 2) ? 40 : -60), 1, 3);
    end
    checkOutput("t3_gain", gain_out, 2);
    checkOutput("t3_peak", peak_out, 100);
    checkOutput("t3_update", gain_update, 1);

    // 4: clip mid-window at gain 4
    enterAuto(4);
    for (int i = 1; i <= 5; i++) applyStimulus(1, (i % 2) ? 20 : -20, 1, 4);
    applyStimulus(1, -128, 1, 4);
    checkOutput("t4_clip", clip, 1);
    checkOutput("t4_gain", gain_out, 3);
    checkOutput("t4_update", gain_update, 1);
    applyStimulus(0, 0, 1, 4);
    checkOutput("t4_clip_one_cycle", clip, 0);
    for (int i = 1; i <= WIN; i++) begin
      applyStimulus(1, (i % 2) ? 20 : -20, 1, 4);
      if (i == 10) checkOutput("t4_window_restarted", gain_out, 3);
    end
    checkOutput("t4_hold_gain", gain_out, 3);
    checkOutput("t4_hold_peak", peak_out, 20);

    // 5: saturation edges
    enterAuto(0);
    applyStimulus(1, 127, 1, 0);
    checkOutput("t5_clip_g0", clip, 1);
    checkOutput("t5_no_update_g0", gain_update, 0);
    checkOutput("t5_gain_g0", gain_out, 0);
    enterAuto(5);
    for (int i = 1; i <= WIN; i++) applyStimulus(1, (i % 2) ? 5 : -5, 1, 5);
    checkOutput("t5_gain_max", gain_out, 5);
    checkOutput("t5_no_update_max", gain_update, 0);
    checkOutput("t5_peak_max", peak_out, 5);

    // 6: clip on the last sample of a window
    enterAuto(3);
    for (int i = 1; i < WIN; i++) applyStimulus(1, (i % 2) ? 30 : -30, 1, 3);
    applyStimulus(1, 127, 1, 3);
    checkOutput("t6_gain", gain_out, 2);
    checkOutput("t6_peak", peak_out, 127);
    checkOutput("t6_clip", clip, 1);
    applyStimulus(0, 0, 1, 3);
    checkOutput("t6_single_dec", gain_out, 2);

    // 7: reset mid-window
    enterAuto(2);
    for (int i = 1; i <= 7; i++) applyStimulus(1, (i % 2) ? 10 : -10, 1, 2);
    sample_valid = 1'b1;
    if_filt_out = 8'sd10;
    #2;
    RSTb = 1'b0;
    #1;
    checkOutput("t7_async_gain", gain_out, 0);
    checkOutput("t7_async_peak", peak_out, 0);
    checkOutput("t7_async_clip", clip, 0);
    checkOutput("t7_async_update", gain_update, 0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("t7_held_gain", gain_out, 0);
    #2;
    RSTb = 1'b1;
    applyStimulus(0, 0, 1, 2);
    for (int i = 1; i <= WIN; i++) begin
      applyStimulus(1, (i % 2) ? 10 : -10, 1, 2);
      if (i == WIN - 1) checkOutput("t7_gain_pre", gain_out, 0);
    end
    checkOutput("t7_gain_window", gain_out, 1);
    checkOutput("t7_peak_window", peak_out, 10);

    // Random traffic against the model
    en_r = 1'b1;
    man_r = 3;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        en_r = !en_r;
        man_r = int'($urandom_range(0, 7));
      end
      r = int'($urandom_range(0, 99));
      if (r < 3) x = ($urandom_range(0, 1) != 0) ? 127 : -128;
      else if (r < 15) x = int'($urandom_range(80, 126));
      else x = int'($urandom_range(0, 30));
      if (r >= 3 && $urandom_range(0, 1) != 0) x = -x;
      applyStimulus($urandom_range(0, 3) != 0, x, en_r, man_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
